execute_md: RTL and testbench

EXECUTE_MD -- requirements
Module: execute_md

---
 rtl/execute_md.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_execute_md.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_md.sv
// execute_md: execute stage with integrated multiply/divide unit.
//
// Single-cycle ALU, branch compare, load/store address and jal/jalr target
// generation, with operand forwarding from the mem and wb stages. M-extension
// ops run on a small FSM (IDLE -> MUL|DIV -> DONE -> IDLE). All results are
// registered on the next rising clk edge.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   flush                current and in-flight op become nop (beats stall)
//   stall                downstream stall: hold every registered output
//   rtype..jalr          decode class flags
//   inst, pc, imm        instruction word, pc, sign-extended immediate
//   reg1, reg2, regD     source/destination register ids
//   reg1val, reg2val     register file operand values
//   regD_*_mem/_wb       forwarding sources from mem and wb stages
//   busy                 multi-cycle M op in flight
//   regwrite..regDF      registered results
//   state_dbg            current FSM state (debug visibility)
//
// Handshake: busy is combinational. While busy is high the stage accepts
// nothing new and upstream must hold the M op on the inputs; the op counts
// as consumed on the edge where DONE retires it without stall. stall freezes
// the outputs but never pauses the MUL/DIV counter.
module execute_md #(
    parameter int XLEN           = 32,
    parameter int MUL_STAGES     = 2,
    parameter int DIV_RADIX_BITS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            stall,
    input  logic            rtype,
    input  logic            itype,
    input  logic            load,
    input  logic            store,
    input  logic            branch,
    input  logic            jal,
    input  logic            jalr,
    input  logic [31:0]     inst,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [4:0]      reg1,
    input  logic [4:0]      reg2,
    input  logic [4:0]      regD,
    input  logic [XLEN-1:0] reg1val,
    input  logic [XLEN-1:0] reg2val,
    input  logic [4:0]      regD_mem,
    input  logic [4:0]      regD_wb,
    input  logic [XLEN-1:0] regD_val_mem,
    input  logic [XLEN-1:0] regD_val_wb,
    input  logic            regwrite_mem,
    input  logic            regwrite_wb,
    output logic            busy,
    output logic            regwrite,
    output logic            loadF,
    output logic            storeF,
    output logic            jalF,
    output logic            jalrF,
    output logic            branch_cond,
    output logic [XLEN-1:0] target,
    output logic [XLEN-1:0] result,
    output logic [XLEN-1:0] store_data,
    output logic [4:0]      regDF,
    output logic [1:0]      state_dbg
);

    localparam int SHW        = $clog2(XLEN);
    localparam int DIV_CYCLES = (XLEN + DIV_RADIX_BITS - 1) / DIV_RADIX_BITS;
    localparam int CNT_W      = $clog2(DIV_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic               issue;

    logic [XLEN-1:0]    fwd1, fwd2, alu_b, alu_out, ex_result, ex_target, addr_sum;
    logic [SHW-1:0]     shamt;
    logic               ex_wr, ex_bcond, m_op;

    // Captured M op context.
    logic [XLEN-1:0]    m_a, m_b, div_quo, step_quo;
    logic [XLEN:0]      div_rem, step_rem;
    logic [2:0]         m_f3;
    logic [4:0]         m_rd;
    logic               q_neg, r_neg, div_zero;
    logic               a_neg, b_neg;
    logic [XLEN-1:0]    abs_a, abs_b, m_result, q_fix, r_fix;
    logic               a_sgn, b_sgn;
    logic signed [2*XLEN+1:0] mul_a, mul_b, mul_full;

    logic unused_bits;
    assign unused_bits = ^{inst[24:15], inst[11:0], mul_full[2*XLEN+1:2*XLEN]};

    assign state_dbg = state;

    // Operand forwarding: mem beats wb beats register file; x0 never forwards.
    always_comb begin
        fwd1 = reg1val;
        if (regwrite_mem && regD_mem != 5'd0 && regD_mem == reg1)   fwd1 = regD_val_mem;
        else if (regwrite_wb && regD_wb != 5'd0 && regD_wb == reg1) fwd1 = regD_val_wb;
        fwd2 = reg2val;
        if (regwrite_mem && regD_mem != 5'd0 && regD_mem == reg2)   fwd2 = regD_val_mem;
        else if (regwrite_wb && regD_wb != 5'd0 && regD_wb == reg2) fwd2 = regD_val_wb;
    end

    assign m_op = rtype && (inst[31:25] == 7'h01);

    // Single-cycle ALU / branch / address path.
    always_comb begin
        alu_b    = itype ? imm : fwd2;
        shamt    = alu_b[SHW-1:0];
        addr_sum = fwd1 + imm;
        unique case (inst[14:12])
            3'd0:    alu_out = (rtype && inst[30]) ? fwd1 - alu_b : fwd1 + alu_b;
            3'd1:    alu_out = fwd1 << shamt;
            3'd2:    alu_out = {{(XLEN-1){1'b0}}, $signed(fwd1) < $signed(alu_b)};
            3'd3:    alu_out = {{(XLEN-1){1'b0}}, fwd1 < alu_b};
            3'd4:    alu_out = fwd1 ^ alu_b;
            3'd5:    alu_out = inst[30] ? XLEN'($signed(fwd1) >>> shamt) : fwd1 >> shamt;
            3'd6:    alu_out = fwd1 | alu_b;
            default: alu_out = fwd1 & alu_b;
        endcase
        unique case (inst[14:12])
            3'd0:    ex_bcond = (fwd1 == fwd2);
            3'd1:    ex_bcond = (fwd1 != fwd2);
            3'd4:    ex_bcond = $signed(fwd1) < $signed(fwd2);
            3'd5:    ex_bcond = $signed(fwd1) >= $signed(fwd2);
            3'd6:    ex_bcond = fwd1 < fwd2;
            3'd7:    ex_bcond = fwd1 >= fwd2;
            default: ex_bcond = 1'b0;
        endcase
        ex_bcond = ex_bcond & branch;
        ex_wr    = (rtype | itype | load | jal | jalr) & (regD != 5'd0);
        if (jal || jalr)         ex_result = pc + XLEN'(4);
        else if (load || store)  ex_result = addr_sum;
        else if (rtype || itype) ex_result = alu_out;
        else                     ex_result = '0;
        if (jalr)                ex_target = addr_sum & {{(XLEN-1){1'b1}}, 1'b0};
        else if (branch || jal)  ex_target = pc + imm;
        else                     ex_target = '0;
    end

    // Divide operand conditioning: signed ops run on magnitudes, sign fixed at the end.
    always_comb begin
        a_neg = inst[14] && !inst[12] && fwd1[XLEN-1];
        b_neg = inst[14] && !inst[12] && fwd2[XLEN-1];
        abs_a = a_neg ? -fwd1 : fwd1;
        abs_b = b_neg ? -fwd2 : fwd2;
    end

    // One divide cycle: DIV_RADIX_BITS restoring shift-subtract steps.
    always_comb begin
        step_rem = div_rem;
        step_quo = div_quo;
        for (int i = 0; i < DIV_RADIX_BITS; i++) begin
            step_rem = {step_rem[XLEN-1:0], step_quo[XLEN-1]};
            step_quo = {step_quo[XLEN-2:0], 1'b0};
            if (step_rem >= {1'b0, m_b}) begin
                step_rem    = step_rem - {1'b0, m_b};
                step_quo[0] = 1'b1;
            end
        end
    end

    // M result from captured operands; min/-1 falls out of the magnitude path.
    always_comb begin
        a_sgn    = (m_f3[1:0] == 2'd1) || (m_f3[1:0] == 2'd2);
        b_sgn    = (m_f3[1:0] == 2'd1);
        mul_a    = $signed({{(XLEN+2){a_sgn & m_a[XLEN-1]}}, m_a});
        mul_b    = $signed({{(XLEN+2){b_sgn & m_b[XLEN-1]}}, m_b});
        mul_full = mul_a * mul_b;
        q_fix    = q_neg ? -div_quo : div_quo;
        r_fix    = r_neg ? -div_rem[XLEN-1:0] : div_rem[XLEN-1:0];
        if (div_zero) begin
            q_fix = '1;
            r_fix = m_a;
        end
        if (m_f3[2])               m_result = m_f3[1] ? r_fix : q_fix;
        else if (m_f3[1:0] == 2'd0) m_result = mul_full[XLEN-1:0];
        else                        m_result = mul_full[2*XLEN-1:XLEN];
    end

    // FSM next state and busy.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        busy     = 1'b0;
        issue    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (m_op && !stall && !flush) begin
                    issue = 1'b1;
                    busy  = 1'b1;
                    if (inst[14]) begin
                        state_nx = S_DIV;
                        cnt_nx   = CNT_W'(DIV_CYCLES - 1);
                    end else if (MUL_STAGES > 1) begin
                        state_nx = S_MUL;
                        cnt_nx   = CNT_W'((MUL_STAGES > 1) ? MUL_STAGES - 2 : 0);
                    end else begin
                        state_nx = S_DONE;
                    end
                end
            end
            S_MUL, S_DIV: begin
                busy = 1'b1;
                if (cnt == '0) state_nx = S_DONE;
                else           cnt_nx   = cnt - 1'b1;
            end
            default: begin
                if (!stall) state_nx = S_IDLE;
            end
        endcase
        if (flush) begin
            state_nx = S_IDLE;
            cnt_nx   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_a <= '0; m_b <= '0; m_f3 <= '0; m_rd <= '0;
            div_rem <= '0; div_quo <= '0;
            q_neg <= 1'b0; r_neg <= 1'b0; div_zero <= 1'b0;
        end else if (issue) begin
            m_a      <= fwd1;
            m_b      <= inst[14] ? abs_b : fwd2;
            m_f3     <= inst[14:12];
            m_rd     <= regD;
            div_rem  <= '0;
            div_quo  <= inst[14] ? abs_a : '0;
            q_neg    <= a_neg ^ b_neg;
            r_neg    <= a_neg;
            div_zero <= (fwd2 == '0);
        end else if (state == S_DIV) begin
            div_rem <= step_rem;
            div_quo <= step_quo;
        end
    end

    // Registered outputs: rst > flush > stall hold > busy nop > M retire > normal.
    always_ff @(posedge clk) begin
        if (rst || flush || (!stall && busy)) begin
            regwrite <= 1'b0; loadF <= 1'b0; storeF <= 1'b0; jalF <= 1'b0;
            jalrF <= 1'b0; branch_cond <= 1'b0; regDF <= '0;
            target <= '0; result <= '0; store_data <= '0;
        end else if (!stall) begin
            if (state == S_DONE) begin
                regwrite <= (m_rd != 5'd0); loadF <= 1'b0; storeF <= 1'b0; jalF <= 1'b0;
                jalrF <= 1'b0; branch_cond <= 1'b0; regDF <= m_rd;
                target <= '0; result <= m_result; store_data <= '0;
            end else begin
                regwrite    <= ex_wr;
                regDF       <= ex_wr ? regD : 5'd0;
                loadF       <= load;
                storeF      <= store;
                jalF        <= jal;
                jalrF       <= jalr;
                branch_cond <= ex_bcond;
                target      <= ex_target;
                result      <= ex_result;
                store_data  <= store ? fwd2 : '0;
            end
        end
    end

endmodule

// File: tb/tb_execute_md.sv
// tb_execute_md: directed-vector bench for execute_md (XLEN=32, MUL_STAGES=2,
// DIV_RADIX_BITS=1). Inputs change 1ns after the rising edge; outputs are
// sampled at the same point, after the edge has settled.
module tb_execute_md;

    logic        clk = 1'b0;
    logic        rst, flush, stall;
    logic        rtype, itype, load, store, branch, jal, jalr;
    logic [31:0] inst, pc, imm;
    logic [4:0]  reg1, reg2, regD, regD_mem, regD_wb;
    logic [31:0] reg1val, reg2val, regD_val_mem, regD_val_wb;
    logic        regwrite_mem, regwrite_wb;
    logic        busy, regwrite, loadF, storeF, jalF, jalrF, branch_cond;
    logic [31:0] target, result, store_data;
    logic [4:0]  regDF;
    logic [1:0]  state_dbg;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic        seen;

    execute_md #(.XLEN(32), .MUL_STAGES(2), .DIV_RADIX_BITS(1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .stall(stall),
        .rtype(rtype), .itype(itype), .load(load), .store(store),
        .branch(branch), .jal(jal), .jalr(jalr),
        .inst(inst), .pc(pc), .imm(imm),
        .reg1(reg1), .reg2(reg2), .regD(regD),
        .reg1val(reg1val), .reg2val(reg2val),
        .regD_mem(regD_mem), .regD_wb(regD_wb),
        .regD_val_mem(regD_val_mem), .regD_val_wb(regD_val_wb),
        .regwrite_mem(regwrite_mem), .regwrite_wb(regwrite_wb),
        .busy(busy), .regwrite(regwrite), .loadF(loadF), .storeF(storeF),
        .jalF(jalF), .jalrF(jalrF), .branch_cond(branch_cond),
        .target(target), .result(result), .store_data(store_data),
        .regDF(regDF), .state_dbg(state_dbg)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Checking
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drivers
    function automatic logic [31:0] enc(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        rtype = 0; itype = 0; load = 0; store = 0; branch = 0; jal = 0; jalr = 0;
        inst = 0; pc = 0; imm = 0; reg1 = 0; reg2 = 0; regD = 0;
        reg1val = 0; reg2val = 0; regD_mem = 0; regD_wb = 0;
        regD_val_mem = 0; regD_val_wb = 0; regwrite_mem = 0; regwrite_wb = 0;
    endtask

    task automatic drive_m(input logic [2:0] f3, input logic [4:0] rd,
                           input logic [31:0] a, input logic [31:0] b);
        clear_in();
        rtype = 1; inst = enc(7'h01, f3, rd, 5'd1, 5'd2);
        reg1 = 1; reg2 = 2; reg1val = a; reg2val = b; regD = rd;
    endtask

    // Full M op: busy-cycle count, quiet DONE, then the retired result.
    task automatic run_mop(input string tag, input logic [2:0] f3, input logic [4:0] rd,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_r, input int exp_busy);
        int bc;
        logic [31:0] e;
        drive_m(f3, rd, a, b);
        exp_q.push_back(exp_r);
        #1;
        bc = 0;
        while (busy && bc < 200) begin
            bc++;
            step();
        end
        check({tag, "_busy_cycles"}, bc, exp_busy);
        check({tag, "_done_quiet"}, regwrite, 0);
        step();
        e = exp_q.pop_front();
        check({tag, "_result"}, result, e);
        check({tag, "_regwrite"}, regwrite, 1);
        check({tag, "_regdf"}, regDF, rd);
        clear_in();
    endtask

    initial begin
        rst = 1; flush = 0; stall = 0;
        clear_in();
        step();
        step();
        check("rst_result", result, 0);
        check("rst_regwrite", regwrite, 0);
        check("rst_busy", busy, 0);
        check("rst_state", state_dbg, 0);
        rst = 0;

        // add x3,x1,x2 with x1 from mem (7), x2 from wb (5)
        clear_in();
        rtype = 1; inst = enc(7'h00, 3'd0, 5'd3, 5'd1, 5'd2);
        reg1 = 1; reg2 = 2; regD = 3; reg1val = 99; reg2val = 88;
        regwrite_mem = 1; regD_mem = 1; regD_val_mem = 7;
        regwrite_wb = 1; regD_wb = 2; regD_val_wb = 5;
        step();
        check("fwd_add_result", result, 12);
        check("fwd_add_regdf", regDF, 3);
        check("fwd_add_regwrite", regwrite, 1);

        // stall holds the previous result while a new op sits on the inputs
        stall = 1;
        clear_in();
        rtype = 1; inst = enc(7'h00, 3'd0, 5'd9, 5'd1, 5'd2); regD = 9; reg1val = 1; reg2val = 1;
        step();
        check("stall_hold_result", result, 12);
        check("stall_hold_regdf", regDF, 3);
        stall = 0;

        // sub x4,x1,x2: mem beats wb for x1, x2 from regfile -> 7-3
        clear_in();
        rtype = 1; inst = enc(7'h20, 3'd0, 5'd4, 5'd1, 5'd2);
        reg1 = 1; reg2 = 2; regD = 4; reg1val = 99; reg2val = 3;
        regwrite_mem = 1; regD_mem = 1; regD_val_mem = 7;
        regwrite_wb = 1; regD_wb = 1; regD_val_wb = 100;
        step();
        check("fwd_prio_sub", result, 4);

        // x0 is never a forwarding match
        clear_in();
        rtype = 1; inst = enc(7'h00, 3'd0, 5'd6, 5'd0, 5'd2);
        reg1 = 0; reg2 = 2; regD = 6; reg1val = 0; reg2val = 9;
        regwrite_mem = 1; regD_mem = 0; regD_val_mem = 55;
        step();
        check("fwd_x0_add", result, 9);

        // flush turns a live op into nop
        clear_in();
        rtype = 1; inst = enc(7'h00, 3'd0, 5'd7, 5'd1, 5'd2); regD = 7; reg1val = 1; reg2val = 1;
        flush = 1;
        step();
        flush = 0;
        check("flush_op_regwrite", regwrite, 0);
        check("flush_op_result", result, 0);

        // srai by imm[4:0]=4 with inst[30] set
        clear_in();
        itype = 1; inst = enc(7'h20, 3'd5, 5'd5, 5'd1, 5'd4);
        reg1 = 1; regD = 5; reg1val = 32'hF000_0000; imm = 32'h0000_0404;
        step();
        check("srai", result, 32'hFF00_0000);

        // srl uses only the low 5 bits of rs2
        clear_in();
        rtype = 1; inst = enc(7'h00, 3'd5, 5'd5, 5'd1, 5'd2);
        reg1 = 1; reg2 = 2; regD = 5; reg1val = 32'h8000_0000; reg2val = 32'h21;
        step();
        check("srl_shamt_mask", result, 32'h4000_0000);

        // slt / sltu on -1 vs 1
        clear_in();
        rtype = 1; inst = enc(7'h00, 3'd2, 5'd5, 5'd1, 5'd2);
        reg1 = 1; reg2 = 2; regD = 5; reg1val = 32'hFFFF_FFFF; reg2val = 1;
        step();
        check("slt", result, 1);
        inst = enc(7'h00, 3'd3, 5'd5, 5'd1, 5'd2);
        step();
        check("sltu", result, 0);

        // jalr: target (rs1+imm)&~1, result pc+4
        clear_in();
        jalr = 1; reg1 = 1; regD = 1; reg1val = 32'h203; imm = 4; pc = 32'h100;
        step();
        check("jalr_target", target, 32'h206);
        check("jalr_result", result, 32'h104);
        check("jalr_flag", jalrF, 1);

        // bne taken
        clear_in();
        branch = 1; inst = enc(7'h00, 3'd1, 5'd0, 5'd1, 5'd2);
        reg1 = 1; reg2 = 2; reg1val = 1; reg2val = 2; pc = 32'h100; imm = 32'h20;
        step();
        check("bne_cond", branch_cond, 1);
        check("bne_target", target, 32'h120);
        check("bne_regwrite", regwrite, 0);

        // store address and data
        clear_in();
        store = 1; reg1 = 1; reg2 = 5; reg1val = 32'h1000; reg2val = 32'hDEAD_BEEF; imm = 8;
        step();
        check("store_addr", result, 32'h1008);
        check("store_data", store_data, 32'hDEAD_BEEF);
        check("store_regwrite", regwrite, 0);
        check("store_flag", storeF, 1);

        // write to x0 is suppressed
        clear_in();
        rtype = 1; inst = enc(7'h00, 3'd0, 5'd0, 5'd1, 5'd2); reg1val = 5; reg2val = 5;
        step();
        check("x0_regwrite", regwrite, 0);
        check("x0_regdf", regDF, 0);

        // multiply / divide vectors
        run_mop("mulh_min", 3'd1, 5'd8, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2);
        run_mop("mul", 3'd0, 5'd8, 32'd6, 32'd7, 32'd42, 2);
        run_mop("mulhsu", 3'd2, 5'd8, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 2);
        run_mop("mulhu", 3'd3, 5'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2);
        run_mop("div_ovf", 3'd4, 5'd9, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);
        run_mop("rem_ovf", 3'd6, 5'd9, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33);
        run_mop("divu_zero", 3'd5, 5'd9, 32'd9, 32'd0, 32'hFFFF_FFFF, 33);
        run_mop("remu_zero", 3'd7, 5'd9, 32'd9, 32'd0, 32'd9, 33);
        run_mop("div_neg", 3'd4, 5'd9, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        run_mop("rem_neg", 3'd6, 5'd9, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);

        // stall arriving mid-MUL and held 3 cycles across DONE of 6*7
        drive_m(3'd0, 5'd10, 32'd6, 32'd7);
        exp_q.push_back(32'd42);
        #1;
        check("stall_mul_issue_busy", busy, 1);
        step();
        stall = 1;
        step();
        check("stall_mul_counter_runs", state_dbg, 3);
        check("stall_mul_frozen1", regwrite, 0);
        step();
        check("stall_mul_frozen2", result, 0);
        step();
        check("stall_mul_frozen3", regwrite, 0);
        stall = 0;
        step();
        check("stall_mul_result", result, exp_q.pop_front());
        check("stall_mul_regdf", regDF, 10);
        clear_in();

        // flush 5 cycles into a divide
        drive_m(3'd4, 5'd11, 32'd100, 32'd7);
        #1;
        check("flush_div_issue_busy", busy, 1);
        repeat (5) step();
        flush = 1;
        step();
        flush = 0;
        clear_in();
        #1;
        check("flush_div_busy", busy, 0);
        check("flush_div_regwrite", regwrite, 0);
        check("flush_div_state", state_dbg, 0);
        seen = 0;
        repeat (40) begin
            step();
            if (regwrite) seen = 1;
        end
        check("flush_div_no_result", seen, 0);

        // reset overrides stall on a live result
        clear_in();
        rtype = 1; inst = enc(7'h00, 3'd0, 5'd3, 5'd1, 5'd2); regD = 3; reg1val = 2; reg2val = 3;
        step();
        check("pre_rst_result", result, 5);
        rst = 1; stall = 1;
        step();
        check("rst_over_stall_result", result, 0);
        rst = 0; stall = 0;

        // reset mid-divide with flush and stall high
        drive_m(3'd5, 5'd12, 32'd1000, 32'd3);
        repeat (4) step();
        rst = 1; flush = 1; stall = 1;
        step();
        clear_in();
        #1;
        check("rst_div_busy", busy, 0);
        check("rst_div_result", result, 0);
        check("rst_div_regwrite", regwrite, 0);
        rst = 0; flush = 0; stall = 0;
        seen = 0;
        repeat (40) begin
            step();
            if (regwrite) seen = 1;
        end
        check("rst_div_no_result", seen, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
